winograd_pe_accum: RTL and testbench
====================================

Name: winograd_pe_accum

Overview:
- Downstream consumer of the input-transform stage. Takes each transformed 6x6 input tile (V, signed 14-bit) with its block address and multiplies it element-wise by a held transformed-weight tile (U).
- Accumulates the 36 products per block address across input channels in a local accumulator file.
- On the last channel of a pass, emits the finished 6x6 M tile to the output-transform stage.
- One instance per lane; the top level instantiates two, one per transform output lane.

Parameters:
- MAX_BLOCKS, 16, number of accumulator entries (block addresses 0..MAX_BLOCKS-1).
- DATA_W, 14, width of incoming transformed data elements.
- WGT_W, 16, width of transformed weight elements.
- ACC_W, 32, accumulator / output element width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- weight_tile_i  in  [5:0][5:0] x WGT_W signed  transformed weight tile U
- weight_valid_i  in  1  load weight_tile_i into the weight register
- data_tile_i  in  [5:0][5:0] x DATA_W signed  transformed input tile V
- data_addr_i  in  8  block address of data_tile_i
- data_valid_i  in  1  data_tile_i / data_addr_i valid this cycle
- channel_first_i  in  1  qualifies data_valid_i: first input channel, so overwrite instead of accumulate
- channel_last_i  in  1  qualifies data_valid_i: last input channel, so emit the result
- acc_tile_o  out  [5:0][5:0] x ACC_W signed  accumulated M tile
- acc_addr_o  out  8  block address of acc_tile_o
- acc_valid_o  out  1  acc_tile_o valid (one-cycle pulse per tile)
- addr_err_o  out  1  sticky flag: a valid tile had data_addr_i >= MAX_BLOCKS
- Clock is clk; reset is synchronous and active-high, named reset.

Behaviour:
- Reset (synchronous, active-high): all registers are cleared.
  - Weight register, accumulator file and pipeline registers go to 0.
  - acc_tile_o = 0, acc_addr_o = 0, acc_valid_o = 0, addr_err_o = 0.
  - Reset mid-operation drops all in-flight tiles; no output is emitted for them.
- Weight register: loads weight_tile_i on the edge where weight_valid_i = 1.
  - A tile with data_valid_i in the same cycle uses the old weight. The new weight applies from the next cycle.
- Stage 1 (edge after data_valid_i): p[i][j] = data_tile_i[i][j] * w_reg[i][j], signed, full precision (DATA_W+WGT_W = 30 bits).
  - Stage 1 also registers addr, first, last and valid.
- Stage 2 (next edge): sign-extend p to ACC_W. Then:
  - first = 1: s = p.
  - first = 0: s = acc[addr] + p, wrapping two's complement at ACC_W. No saturation.
  - acc[addr] <= s.
  - last = 1: acc_tile_o <= s, acc_addr_o <= addr, acc_valid_o <= 1.
  - Otherwise acc_valid_o <= 0 and acc_tile_o / acc_addr_o hold their previous values.
- Latency: data_valid_i at cycle N gives acc_valid_o at N+2. Throughput is one tile per cycle with no stalls.
- first and last both 1 (single-channel layer): output = p and acc is written with p.
- The accumulator file is read combinationally in stage 2. Back-to-back tiles to the same address (block_cnt = 1) therefore accumulate correctly with no bubble and no bypass logic.
- Out-of-range address (>= MAX_BLOCKS): the tile is dropped in stage 2.
  - No accumulator write, no acc_valid_o.
  - addr_err_o set to 1 and held until reset.
- data_valid_i = 0: channel_first_i, channel_last_i and data_addr_i are don't-care. The pipeline valid bit clears.
- No backpressure: the consumer must accept acc_valid_o in the cycle it is asserted.

Decomposition:
- Shared package (wino_pkg) holds:
  - Tile dimension constant TILE = 6.
  - Typedefs for the V tile (6x6 x 14-bit signed), U tile (6x6 x 16-bit signed) and M tile (6x6 x 32-bit signed).
  - Default MAX_BLOCKS.
- Optional sub-module wino_ewmul: the 36-way element-wise signed multiply plus its stage-1 register.
- Accumulator file and control stay in the top module.

Test Plan:
- Reset then idle: drive no valids for 10 cycles -> acc_valid_o = 0, acc_tile_o all 0, addr_err_o = 0.
- Single channel: U all 2, V all 3, addr 5, first = last = 1 -> at N+2, acc_valid_o = 1, acc_addr_o = 5, all 36 elements = 6.
- Three-channel accumulate: U all 1; V = 10, -4, 7 at addr 0 (first on the first tile, last on the third) -> one output, all elements 13, valid only on the third tile's N+2.
- Back-to-back same address: V = 100 then 100 at addr 0 on consecutive cycles (first, then last), U = -3 -> output all -600.
- Weight swap coincident with data: weight_valid_i with U = 5 in the same cycle as V = 1 (old U = 1), first = last = 1 -> output 1. The next identical tile outputs 5.
- Out-of-range and mid-run reset:
  - Tile at addr MAX_BLOCKS (16) -> no acc_valid_o, addr_err_o = 1 and sticky.
  - Reset asserted one cycle after a last tile -> no acc_valid_o, addr_err_o cleared.

Source files
------------

// File: rtl/wino_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : wino_pkg                                                   |
// | Purpose : Shared constants and tile typedefs for the Winograd PE     |
// |           accumulation stage (6x6 V, U and M tiles).                 |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package wino_pkg;

  localparam int TILE           = 6;
  localparam int ADDR_W         = 8;
  localparam int MAX_BLOCKS_DEF = 16;
  localparam int DATA_W_DEF     = 14;
  localparam int WGT_W_DEF      = 16;
  localparam int ACC_W_DEF      = 32;

  // Element types are named signed types so that indexing a tile yields a
  // signed element.
  typedef logic signed [DATA_W_DEF-1:0] v_elem_t;
  typedef logic signed [WGT_W_DEF-1:0]  u_elem_t;
  typedef logic signed [ACC_W_DEF-1:0]  m_elem_t;

  typedef v_elem_t [TILE-1:0][TILE-1:0] v_tile_t;
  typedef u_elem_t [TILE-1:0][TILE-1:0] u_tile_t;
  typedef m_elem_t [TILE-1:0][TILE-1:0] m_tile_t;

endpackage
`default_nettype wire

// File: rtl/winograd_pe_accum_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : winograd_pe_accum_if                                       |
// | Purpose : Tile/weight input bus and accumulated-tile output bus of   |
// |           one Winograd PE lane.                                      |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
interface winograd_pe_accum_if #(
  parameter int DATA_W = wino_pkg::DATA_W_DEF,
  parameter int WGT_W  = wino_pkg::WGT_W_DEF,
  parameter int ACC_W  = wino_pkg::ACC_W_DEF
);

  // Upstream: weights and transformed input tiles
  logic [wino_pkg::TILE-1:0][wino_pkg::TILE-1:0][WGT_W-1:0]  weight_tile_i;
  logic                                                      weight_valid_i;
  logic [wino_pkg::TILE-1:0][wino_pkg::TILE-1:0][DATA_W-1:0] data_tile_i;
  logic [wino_pkg::ADDR_W-1:0]                               data_addr_i;
  logic                                                      data_valid_i;
  logic                                                      channel_first_i;
  logic                                                      channel_last_i;

  // Downstream: finished M tiles and error status
  logic [wino_pkg::TILE-1:0][wino_pkg::TILE-1:0][ACC_W-1:0]  acc_tile_o;
  logic [wino_pkg::ADDR_W-1:0]                               acc_addr_o;
  logic                                                      acc_valid_o;
  logic                                                      addr_err_o;

  modport master (
    output weight_tile_i, weight_valid_i, data_tile_i, data_addr_i,
           data_valid_i, channel_first_i, channel_last_i,
    input  acc_tile_o, acc_addr_o, acc_valid_o, addr_err_o
  );

  modport slave (
    input  weight_tile_i, weight_valid_i, data_tile_i, data_addr_i,
           data_valid_i, channel_first_i, channel_last_i,
    output acc_tile_o, acc_addr_o, acc_valid_o, addr_err_o
  );

endinterface
`default_nettype wire

// File: rtl/wino_ewmul.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : wino_ewmul                                                 |
// | Purpose : 36-way element-wise signed multiply V .* U with its        |
// |           stage-1 register (products plus address/first/last/valid). |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module wino_ewmul #(
  parameter int DATA_W = wino_pkg::DATA_W_DEF,
  parameter int WGT_W  = wino_pkg::WGT_W_DEF,
  parameter int ADDR_W = wino_pkg::ADDR_W
) (
  input  logic                                                             clk,
  input  logic                                                             reset,
  input  logic [wino_pkg::TILE-1:0][wino_pkg::TILE-1:0][DATA_W-1:0]        data_tile_i,
  input  logic [wino_pkg::TILE-1:0][wino_pkg::TILE-1:0][WGT_W-1:0]         weight_tile_i,
  input  logic [ADDR_W-1:0]                                                addr_i,
  input  logic                                                             valid_i,
  input  logic                                                             first_i,
  input  logic                                                             last_i,
  output logic [wino_pkg::TILE-1:0][wino_pkg::TILE-1:0][DATA_W+WGT_W-1:0]  prod_o,
  output logic [ADDR_W-1:0]                                                addr_o,
  output logic                                                             valid_o,
  output logic                                                             first_o,
  output logic                                                             last_o
);
  import wino_pkg::*;

  localparam int PROD_W = DATA_W + WGT_W;

  logic [TILE-1:0][TILE-1:0][PROD_W-1:0] prod_d, prod_q;
  logic [ADDR_W-1:0]                     addr_d, addr_q;
  logic                                  valid_d, valid_q;
  logic                                  first_d, first_q;
  logic                                  last_d, last_q;

  // Operands are sign-extended to the full product width; the low PROD_W
  // bits of that product are the exact signed product.
  function automatic logic [PROD_W-1:0] sext_data(input logic [DATA_W-1:0] x);
    return {{WGT_W{x[DATA_W-1]}}, x};
  endfunction

  function automatic logic [PROD_W-1:0] sext_wgt(input logic [WGT_W-1:0] x);
    return {{DATA_W{x[WGT_W-1]}}, x};
  endfunction

  // Next-state: capture products and sideband only for valid tiles
  always_comb begin
    prod_d  = prod_q;
    addr_d  = addr_q;
    first_d = first_q;
    last_d  = last_q;
    valid_d = valid_i;
    if (valid_i) begin
      addr_d  = addr_i;
      first_d = first_i;
      last_d  = last_i;
      for (int i = 0; i < TILE; i++) begin
        for (int j = 0; j < TILE; j++) begin
          prod_d[i][j] = sext_data(data_tile_i[i][j]) * sext_wgt(weight_tile_i[i][j]);
        end
      end
    end
  end

  // Stage-1 register
  always_ff @(posedge clk) begin
    if (reset) begin
      prod_q  <= '0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      prod_q  <= prod_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      first_q <= first_d;
      last_q  <= last_d;
    end
  end

  assign prod_o  = prod_q;
  assign addr_o  = addr_q;
  assign valid_o = valid_q;
  assign first_o = first_q;
  assign last_o  = last_q;

endmodule
`default_nettype wire

// File: rtl/winograd_pe_accum.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : winograd_pe_accum                                          |
// | Purpose : One Winograd PE lane: holds the U tile, multiplies incoming|
// |           V tiles element-wise, accumulates per block address across |
// |           input channels and emits the M tile on the last channel.   |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module winograd_pe_accum #(
  parameter int MAX_BLOCKS = wino_pkg::MAX_BLOCKS_DEF,
  parameter int DATA_W     = wino_pkg::DATA_W_DEF,
  parameter int WGT_W      = wino_pkg::WGT_W_DEF,
  parameter int ACC_W      = wino_pkg::ACC_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  winograd_pe_accum_if.slave  bus
);
  import wino_pkg::*;

  localparam int                PROD_W      = DATA_W + WGT_W;
  localparam int                IDX_W       = (MAX_BLOCKS > 1) ? $clog2(MAX_BLOCKS) : 1;
  localparam logic [ADDR_W-1:0] BLOCK_LIMIT = ADDR_W'(MAX_BLOCKS);

  typedef logic [TILE-1:0][TILE-1:0][ACC_W-1:0] acc_tile_t;

  // Weight register
  logic [TILE-1:0][TILE-1:0][WGT_W-1:0] weight_d, weight_q;

  // Stage-1 outputs
  logic [TILE-1:0][TILE-1:0][PROD_W-1:0] s1_prod;
  logic [ADDR_W-1:0]                     s1_addr;
  logic                                  s1_valid;
  logic                                  s1_first;
  logic                                  s1_last;

  // Accumulator file and stage-2 output registers
  acc_tile_t         acc_d [MAX_BLOCKS];
  acc_tile_t         acc_q [MAX_BLOCKS];
  acc_tile_t         tile_d, tile_q;
  logic [ADDR_W-1:0] out_addr_d, out_addr_q;
  logic              out_valid_d, out_valid_q;
  logic              err_d, err_q;

  // Stage-2 combinational terms
  acc_tile_t         sum;
  logic [IDX_W-1:0]  idx;
  logic              in_range;

  // A newly loaded weight only affects tiles arriving after this edge
  always_comb begin
    weight_d = bus.weight_valid_i ? bus.weight_tile_i : weight_q;
  end

  wino_ewmul #(
    .DATA_W (DATA_W),
    .WGT_W  (WGT_W),
    .ADDR_W (ADDR_W)
  ) u_ewmul (
    .clk           (clk),
    .reset         (reset),
    .data_tile_i   (bus.data_tile_i),
    .weight_tile_i (weight_q),
    .addr_i        (bus.data_addr_i),
    .valid_i       (bus.data_valid_i),
    .first_i       (bus.channel_first_i),
    .last_i        (bus.channel_last_i),
    .prod_o        (s1_prod),
    .addr_o        (s1_addr),
    .valid_o       (s1_valid),
    .first_o       (s1_first),
    .last_o        (s1_last)
  );

  // Accumulate: the file is read combinationally so back-to-back tiles to
  // one address see the value written on the previous edge, no bypass.
  always_comb begin
    idx      = s1_addr[IDX_W-1:0];
    in_range = (s1_addr < BLOCK_LIMIT);
    for (int i = 0; i < TILE; i++) begin
      for (int j = 0; j < TILE; j++) begin
        sum[i][j] = (s1_first ? '0 : acc_q[idx][i][j])
                  + {{(ACC_W-PROD_W){s1_prod[i][j][PROD_W-1]}}, s1_prod[i][j]};
      end
    end
  end

  // Next-state for accumulator file, output tile and sticky error
  always_comb begin
    acc_d       = acc_q;
    tile_d      = tile_q;
    out_addr_d  = out_addr_q;
    out_valid_d = 1'b0;
    err_d       = err_q;
    if (s1_valid) begin
      if (in_range) begin
        acc_d[idx] = sum;
        if (s1_last) begin
          tile_d      = sum;
          out_addr_d  = s1_addr;
          out_valid_d = 1'b1;
        end
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // State registers; reset drops any tile still in the pipeline
  always_ff @(posedge clk) begin
    if (reset) begin
      weight_q    <= '0;
      acc_q       <= '{default: '0};
      tile_q      <= '0;
      out_addr_q  <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      weight_q    <= weight_d;
      acc_q       <= acc_d;
      tile_q      <= tile_d;
      out_addr_q  <= out_addr_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

  assign bus.acc_tile_o  = tile_q;
  assign bus.acc_addr_o  = out_addr_q;
  assign bus.acc_valid_o = out_valid_q;
  assign bus.addr_err_o  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_winograd_pe_accum.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_winograd_pe_accum                                       |
// | Purpose : Self-checking bench for winograd_pe_accum: directed        |
// |           scenarios plus randomized traffic against a tile model.    |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_winograd_pe_accum;
  import wino_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  typedef struct {
    bit         v;
    logic [7:0] addr;
    m_tile_t    t;
    bit         err;
  } exp_t;

  always #5 clk = ~clk;

  winograd_pe_accum_if bus ();

  winograd_pe_accum #(
    .MAX_BLOCKS (MAX_BLOCKS_DEF),
    .DATA_W     (DATA_W_DEF),
    .WGT_W      (WGT_W_DEF),
    .ACC_W      (ACC_W_DEF)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic v_tile_t v_fill(input int x);
    v_tile_t t;
    for (int i = 0; i < TILE; i++) for (int j = 0; j < TILE; j++) t[i][j] = v_elem_t'(x);
    return t;
  endfunction

  function automatic u_tile_t u_fill(input int x);
    u_tile_t t;
    for (int i = 0; i < TILE; i++) for (int j = 0; j < TILE; j++) t[i][j] = u_elem_t'(x);
    return t;
  endfunction

  function automatic m_tile_t m_fill(input int x);
    m_tile_t t;
    for (int i = 0; i < TILE; i++) for (int j = 0; j < TILE; j++) t[i][j] = m_elem_t'(x);
    return t;
  endfunction

  function automatic int first_diff(input m_tile_t a, input m_tile_t b);
    for (int k = 0; k < TILE*TILE; k++) if (a[k/TILE][k%TILE] !== b[k/TILE][k%TILE]) return k;
    return 0;
  endfunction

  task automatic drive(input bit dv, input int addr, input bit f, input bit l,
                       input v_tile_t v, input bit wv, input u_tile_t w);
    bus.data_valid_i    = dv;
    bus.data_addr_i     = addr[7:0];
    bus.channel_first_i = f;
    bus.channel_last_i  = l;
    bus.data_tile_i     = v;
    bus.weight_valid_i  = wv;
    bus.weight_tile_i   = w;
  endtask

  task automatic idle();
    drive(1'b0, 0, 1'b0, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    m_tile_t got;
    int      k;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      step();
      n_tests++;
      if (bus.acc_valid_o !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_idle_valid cycle %0d: got %b want 0", c, bus.acc_valid_o);
      end
    end
    got = bus.acc_tile_o;
    n_tests++;
    if (got !== m_fill(0)) begin
      n_fail++;
      k = first_diff(got, m_fill(0));
      $display("FAIL reset_tile: elem %0d got %0d want 0", k, got[k/TILE][k%TILE]);
    end
    n_tests++;
    if (bus.acc_addr_o !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_addr: got %0d want 0", bus.acc_addr_o);
    end
    n_tests++;
    if (bus.addr_err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_err: got %b want 0", bus.addr_err_o);
    end
  endtask

  task automatic test_single_channel();
    m_tile_t got;
    int      k;
    drive(1'b0, 0, 1'b0, 1'b0, '0, 1'b1, u_fill(2));
    step();
    drive(1'b1, 5, 1'b1, 1'b1, v_fill(3), 1'b0, '0);
    step();
    n_tests++;
    if (bus.acc_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL single_early_valid: got %b want 0", bus.acc_valid_o);
    end
    idle();
    step();
    n_tests++;
    if (bus.acc_valid_o !== 1'b1) begin
      n_fail++;
      $display("FAIL single_valid: got %b want 1", bus.acc_valid_o);
    end
    n_tests++;
    if (bus.acc_addr_o !== 8'd5) begin
      n_fail++;
      $display("FAIL single_addr: got %0d want 5", bus.acc_addr_o);
    end
    got = bus.acc_tile_o;
    n_tests++;
    if (got !== m_fill(6)) begin
      n_fail++;
      k = first_diff(got, m_fill(6));
      $display("FAIL single_tile: elem %0d got %0d want 6", k, got[k/TILE][k%TILE]);
    end
    step();
    n_tests++;
    if (bus.acc_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL single_pulse: got %b want 0", bus.acc_valid_o);
    end
  endtask

  task automatic test_three_channel();
    m_tile_t got;
    int      k;
    int      vals[3] = '{10, -4, 7};
    drive(1'b0, 0, 1'b0, 1'b0, '0, 1'b1, u_fill(1));
    step();
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 0, c == 0, c == 2, v_fill(vals[c]), 1'b0, '0);
      step();
      n_tests++;
      if (bus.acc_valid_o !== 1'b0) begin
        n_fail++;
        $display("FAIL three_early_valid ch %0d: got %b want 0", c, bus.acc_valid_o);
      end
    end
    idle();
    step();
    n_tests++;
    if (bus.acc_valid_o !== 1'b1) begin
      n_fail++;
      $display("FAIL three_valid: got %b want 1", bus.acc_valid_o);
    end
    got = bus.acc_tile_o;
    n_tests++;
    if (got !== m_fill(13)) begin
      n_fail++;
      k = first_diff(got, m_fill(13));
      $display("FAIL three_tile: elem %0d got %0d want 13", k, got[k/TILE][k%TILE]);
    end
    step();
    n_tests++;
    if (bus.acc_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL three_pulse: got %b want 0", bus.acc_valid_o);
    end
  endtask

  task automatic test_back_to_back();
    m_tile_t got;
    int      k;
    drive(1'b0, 0, 1'b0, 1'b0, '0, 1'b1, u_fill(-3));
    step();
    drive(1'b1, 0, 1'b1, 1'b0, v_fill(100), 1'b0, '0);
    step();
    drive(1'b1, 0, 1'b0, 1'b1, v_fill(100), 1'b0, '0);
    step();
    n_tests++;
    if (bus.acc_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_early_valid: got %b want 0", bus.acc_valid_o);
    end
    idle();
    step();
    n_tests++;
    if (bus.acc_valid_o !== 1'b1 || bus.acc_addr_o !== 8'd0) begin
      n_fail++;
      $display("FAIL b2b_valid_addr: got %b/%0d want 1/0", bus.acc_valid_o, bus.acc_addr_o);
    end
    got = bus.acc_tile_o;
    n_tests++;
    if (got !== m_fill(-600)) begin
      n_fail++;
      k = first_diff(got, m_fill(-600));
      $display("FAIL b2b_tile: elem %0d got %0d want -600", k, got[k/TILE][k%TILE]);
    end
  endtask

  task automatic test_weight_swap();
    m_tile_t got;
    int      k;
    drive(1'b0, 0, 1'b0, 1'b0, '0, 1'b1, u_fill(1));
    step();
    drive(1'b1, 3, 1'b1, 1'b1, v_fill(1), 1'b1, u_fill(5));
    step();
    drive(1'b1, 3, 1'b1, 1'b1, v_fill(1), 1'b0, '0);
    step();
    got = bus.acc_tile_o;
    n_tests++;
    if (bus.acc_valid_o !== 1'b1 || got !== m_fill(1)) begin
      n_fail++;
      k = first_diff(got, m_fill(1));
      $display("FAIL swap_old_weight: valid %b elem %0d got %0d want valid 1 value 1",
               bus.acc_valid_o, k, got[k/TILE][k%TILE]);
    end
    idle();
    step();
    got = bus.acc_tile_o;
    n_tests++;
    if (bus.acc_valid_o !== 1'b1 || got !== m_fill(5)) begin
      n_fail++;
      k = first_diff(got, m_fill(5));
      $display("FAIL swap_new_weight: valid %b elem %0d got %0d want valid 1 value 5",
               bus.acc_valid_o, k, got[k/TILE][k%TILE]);
    end
  endtask

  task automatic test_out_of_range();
    drive(1'b1, MAX_BLOCKS_DEF, 1'b1, 1'b1, v_fill(1), 1'b0, '0);
    step();
    n_tests++;
    if (bus.addr_err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL oor_err_early: got %b want 0", bus.addr_err_o);
    end
    idle();
    step();
    n_tests++;
    if (bus.acc_valid_o !== 1'b0 || bus.addr_err_o !== 1'b1) begin
      n_fail++;
      $display("FAIL oor_drop: valid/err got %b/%b want 0/1", bus.acc_valid_o, bus.addr_err_o);
    end
    repeat (3) step();
    drive(1'b1, 1, 1'b1, 1'b1, v_fill(2), 1'b0, '0);
    step();
    idle();
    step();
    n_tests++;
    if (bus.acc_valid_o !== 1'b1 || bus.addr_err_o !== 1'b1) begin
      n_fail++;
      $display("FAIL oor_sticky: valid/err got %b/%b want 1/1", bus.acc_valid_o, bus.addr_err_o);
    end
  endtask

  task automatic test_mid_reset();
    drive(1'b1, 2, 1'b1, 1'b1, v_fill(2), 1'b0, '0);
    step();
    reset = 1'b1;
    idle();
    step();
    n_tests++;
    if (bus.acc_valid_o !== 1'b0 || bus.addr_err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_drop: valid/err got %b/%b want 0/0", bus.acc_valid_o, bus.addr_err_o);
    end
    reset = 1'b0;
    step();
    n_tests++;
    if (bus.acc_valid_o !== 1'b0 || bus.acc_tile_o !== m_fill(0)) begin
      n_fail++;
      $display("FAIL midreset_after: valid %b elem0 %0d want 0/0",
               bus.acc_valid_o, $signed(bus.acc_tile_o[0][0]));
    end
  endtask

  task automatic test_random();
    int         mw   [TILE][TILE];
    int         wnew [TILE][TILE];
    int         vin  [TILE][TILE];
    int         macc [MAX_BLOCKS_DEF][TILE][TILE];
    v_tile_t    v;
    u_tile_t    w;
    bit         dv, f, l, wv, merr;
    int         addr, k;
    exp_t       prev, cur;
    m_tile_t    hold_t, got;
    logic [7:0] hold_a;

    do_reset();
    merr   = 1'b0;
    hold_t = '0;
    hold_a = '0;
    for (int i = 0; i < TILE; i++) for (int j = 0; j < TILE; j++) mw[i][j] = 0;
    for (int b = 0; b < MAX_BLOCKS_DEF; b++)
      for (int i = 0; i < TILE; i++) for (int j = 0; j < TILE; j++) macc[b][i][j] = 0;
    prev.v = 1'b0; prev.addr = '0; prev.t = '0; prev.err = 1'b0;

    for (int it = 0; it <= 400; it++) begin
      dv = (it < 400) && ($urandom_range(0, 3) != 0);
      f  = ($urandom_range(0, 3) == 0);
      l  = ($urandom_range(0, 2) == 0);
      wv = (it < 400) && ($urandom_range(0, 7) == 0);
      addr = ($urandom_range(0, 15) == 0) ? MAX_BLOCKS_DEF + int'($urandom_range(0, 239))
                                          : int'($urandom_range(0, 3));
      for (int i = 0; i < TILE; i++) begin
        for (int j = 0; j < TILE; j++) begin
          vin[i][j]  = int'($urandom_range(0, 16383)) - 8192;
          wnew[i][j] = int'($urandom_range(0, 65535)) - 32768;
          v[i][j]    = v_elem_t'(vin[i][j]);
          w[i][j]    = u_elem_t'(wnew[i][j]);
        end
      end
      drive(dv, addr, f, l, v, wv, w);

      // Model: tile uses the weight held before this cycle's load
      cur.v = 1'b0;
      if (dv) begin
        if (addr >= MAX_BLOCKS_DEF) begin
          merr = 1'b1;
        end else begin
          for (int i = 0; i < TILE; i++)
            for (int j = 0; j < TILE; j++)
              macc[addr][i][j] = (f ? 0 : macc[addr][i][j]) + vin[i][j] * mw[i][j];
          if (l) begin
            cur.v  = 1'b1;
            hold_a = addr[7:0];
            for (int i = 0; i < TILE; i++)
              for (int j = 0; j < TILE; j++) hold_t[i][j] = m_elem_t'(macc[addr][i][j]);
          end
        end
      end
      cur.addr = hold_a;
      cur.t    = hold_t;
      cur.err  = merr;
      if (wv) mw = wnew;

      step();
      got = bus.acc_tile_o;
      n_tests++;
      if (bus.acc_valid_o !== prev.v) begin
        n_fail++;
        $display("FAIL rand_valid it %0d: got %b want %b", it, bus.acc_valid_o, prev.v);
      end
      n_tests++;
      if (bus.acc_addr_o !== prev.addr) begin
        n_fail++;
        $display("FAIL rand_addr it %0d: got %0d want %0d", it, bus.acc_addr_o, prev.addr);
      end
      n_tests++;
      if (got !== prev.t) begin
        n_fail++;
        k = first_diff(got, prev.t);
        $display("FAIL rand_tile it %0d: elem %0d got %0d want %0d",
                 it, k, got[k/TILE][k%TILE], prev.t[k/TILE][k%TILE]);
      end
      n_tests++;
      if (bus.addr_err_o !== prev.err) begin
        n_fail++;
        $display("FAIL rand_err it %0d: got %b want %b", it, bus.addr_err_o, prev.err);
      end
      prev = cur;
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_single_channel();
    test_three_channel();
    test_back_to_back();
    test_weight_swap();
    test_out_of_range();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "time limit reached");
  end

endmodule
`default_nettype wire
